// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end: synchronises and edge-detects four IRQ lines, latches pending bits,
// applies the software mask, and tracks the single in-service interrupt for the CPU pipeline.
module irq_pending_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] irq_in,
  input  logic       gie,
  input  logic       mask_we,
  input  logic [3:0] mask_wdata,
  input  logic [1:0] irq_id,
  input  logic       irq_take,
  input  logic       irq_eret,
  output logic [3:0] irq_req,
  output logic       irq_en,
  output logic [3:0] irq_mask,
  output logic       irq_active,
  output logic [1:0] irq_cur_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [SYNC_STAGES-1:0][3:0]  sync_q;
  logic [3:0]                   hist_q;
  logic [3:0]                   pending_q;
  logic [3:0]                   mask_q;
  logic [3:0]                   edge_det;
  logic [3:0]                   clr_vec;
  logic                         take_acc;

  // Synchroniser chain followed by a history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;

  assign irq_req  = pending_q & mask_q;
  assign irq_en   = (state_q == PEND) & gie & (|irq_req);
  assign take_acc = irq_take & irq_en;
  assign clr_vec  = take_acc ? (4'b0001 << irq_id) : '0;

  // Set is OR'd in after the clear so a coincident new edge is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_vec) | edge_det;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (mask_we) begin
      mask_q <= mask_wdata;
    end
  end

  assign irq_mask = mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (|irq_req) state_d = PEND;
      end
      PEND: begin
        if (take_acc)          state_d = SERVICE;
        else if (irq_req == '0) state_d = IDLE;
      end
      SERVICE: begin
        if (irq_eret) state_d = (|irq_req) ? PEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // irq_cur_id deliberately holds across eret so software can still read the last source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_active <= 1'b0;
      irq_cur_id <= '0;
    end else if (take_acc) begin
      irq_active <= 1'b1;
      irq_cur_id <= irq_id;
    end else if (irq_eret && (state_q == SERVICE)) begin
      irq_active <= 1'b0;
    end
  end

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Interrupt front-end for the pipeline CPU. It synchronises four asynchronous interrupt lines, edge-detects them and latches pending bits. It applies a software mask and drives the 4-bit request vector and enable of the downstream 4-to-2 priority encoder. It takes the encoder's 2-bit index back, and on the pipeline's accept handshake it clears that source and tracks the single (non-nested) in-service interrupt until return.

## Interface
- SYNC_STAGES, 2, synchroniser depth on each irq_in bit (legal values 2 or 3)
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- irq_in  in  4  raw asynchronous interrupt lines, rising-edge significant
- gie  in  1  global interrupt enable from the CPU status register
- mask_we  in  1  write strobe for mask register
- mask_wdata  in  4  new mask value (1 = source enabled)
- irq_id  in  2  index returned by priority encoder (binary_out)
- irq_take  in  1  pipeline accepts the interrupt this cycle
- irq_eret  in  1  return-from-interrupt retired this cycle
- irq_req  out  4  pending & mask; drives encoder_in
- irq_en  out  1  drives encoder enable; request to pipeline
- irq_mask  out  4  current mask register (readback)
- irq_active  out  1  an interrupt is in service
- irq_cur_id  out  2  index of in-service interrupt

## Operation
- Sync: each irq_in bit passes through SYNC_STAGES flops, then one history flop; edge[i] = sync[i] & ~hist[i].
- Pending: pending[i] sets on edge[i] regardless of mask; clears on accepted take with irq_id == i. Set and clear of the same bit in the same cycle: set wins (new edge never lost).
- Mask: mask_we loads mask_wdata at next edge; masking hides, never clears, pending bits.
- irq_req = pending & mask (combinational).
- FSM states IDLE, PEND, SERVICE:
  - IDLE -> PEND when |irq_req.
  - PEND -> IDLE when irq_req == 0 (masked or cleared); PEND -> SERVICE on irq_take while irq_en = 1.
  - SERVICE -> PEND on irq_eret if |irq_req, else -> IDLE.
- irq_en = (state == PEND) & gie & |irq_req (combinational, so masking or gie drop removes it in the same cycle).
- Accepted take (irq_take & irq_en): clear pending[irq_id], load irq_cur_id <= irq_id, irq_active <= 1.
- irq_take while irq_en = 0: ignored, no state change.
- irq_eret outside SERVICE: ignored. In SERVICE: irq_active <= 0; irq_cur_id holds its last value.
- No nesting: new edges during SERVICE only accumulate in pending.

## Timing
- Reset (async assert, sync release): sync/hist flops, pending, mask, irq_cur_id = 0; irq_active = 0; state IDLE; therefore irq_req = 0, irq_en = 0, irq_mask = 0.
- A line already high at reset release is seen as one rising edge and sets pending once.
- Latency with SYNC_STAGES = 2, irq_in high before edge k: pending set at edge k+2, irq_req visible after k+2, state PEND and irq_en high after edge k+3.
- Take accepted at edge t: pending bit cleared, irq_active = 1, state SERVICE after t; irq_en low from t onward.
- Eret at edge e with other sources pending: irq_en high again after e (state PEND).
- Reset mid-service drops all pending and in-service state immediately.
- Pulse narrower than one clk period may be missed; sources must hold ≥ SYNC_STAGES+1 cycles.

## Test plan
- Reset, mask = 4'b1111, raise irq_in[2] -> irq_req = 4'b0100 after 3 edges, irq_en = 1 after 4; take with irq_id = 2 -> irq_req = 0, irq_active = 1, irq_cur_id = 2.
- Mask = 4'b0000, edge on irq_in[1] -> irq_req = 0, irq_en = 0; then mask = 4'b0010 -> irq_req = 4'b0010 on the next cycle, irq_en one cycle later.
- In SERVICE on id 3, edges on bits 0 and 3 -> irq_en stays 0; eret -> state PEND, irq_req = 4'b1001, irq_en = 1.
- New edge on bit 1 in the same cycle as take of id 1 -> pending[1] remains 1 after take.
- gie = 0 with pending bit 0 -> irq_en = 0 and irq_take ignored (pending unchanged); gie = 1 -> irq_en = 1 the same cycle.
- Assert rst_n = 0 in SERVICE with pending 4'b0110 -> all outputs 0 asynchronously; irq_in held high through release -> single pending set.
